// File: rtl/apb_rr_master.sv
// Round-robin APB master: shares one APB slave port among NUM_REQ requesters,
// sequencing SETUP/ACCESS and aborting ACCESS on a wait-state timeout.
module apb_rr_master #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      P_clk,
  input  logic                      P_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         P_addr,
  output logic                      P_selx,
  output logic                      P_enable,
  output logic                      P_write,
  output logic [DATA_W-1:0]         P_wdata,
  input  logic                      P_ready,
  input  logic                      P_slverr,
  input  logic [DATA_W-1:0]         P_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    p_addr_q, p_addr_d;
  logic [DATA_W-1:0]    p_wdata_q, p_wdata_d;
  logic                 p_write_q, p_write_d;
  logic                 p_selx_q, p_selx_d;
  logic                 p_enable_q, p_enable_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 gnt_found;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 timeout_hit;

  // Rotating-priority search: first asserted requester at or after ptr, with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      automatic int idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && gnt_found) req_ready = NUM_REQ'(1) << gnt_idx;
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge P_clk or posedge P_rst) begin
    if (P_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (gnt_found) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (P_ready || timeout_hit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    p_addr_d    = p_addr_q;
    p_wdata_d   = p_wdata_q;
    p_write_d   = p_write_q;
    p_selx_d    = p_selx_q;
    p_enable_d  = p_enable_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          p_addr_d   = req_addr[gnt_idx*ADDR_W +: ADDR_W];
          p_wdata_d  = req_wdata[gnt_idx*DATA_W +: DATA_W];
          p_write_d  = req_write[gnt_idx];
          p_selx_d   = 1'b1;
          p_enable_d = 1'b0;
          gnt_d      = gnt_idx;
          ptr_d      = IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);
          cnt_d      = '0;
        end
      end
      S_SETUP: p_enable_d = 1'b1;
      S_ACCESS: begin
        if (P_ready) begin
          p_selx_d    = 1'b0;
          p_enable_d  = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << gnt_q;
          rsp_err_d   = P_slverr;
          rsp_rdata_d = p_write_q ? '0 : P_rdata;
          cnt_d       = '0;
        end else if (timeout_hit) begin
          p_selx_d    = 1'b0;
          p_enable_d  = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << gnt_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge P_clk or posedge P_rst) begin
    if (P_rst) begin
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      p_addr_q    <= '0;
      p_wdata_q   <= '0;
      p_write_q   <= 1'b0;
      p_selx_q    <= 1'b0;
      p_enable_q  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      p_addr_q    <= p_addr_d;
      p_wdata_q   <= p_wdata_d;
      p_write_q   <= p_write_d;
      p_selx_q    <= p_selx_d;
      p_enable_q  <= p_enable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign P_addr    = p_addr_q;
  assign P_wdata   = p_wdata_q;
  assign P_write   = p_write_q;
  assign P_selx    = p_selx_q;
  assign P_enable  = p_enable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
